// File: rtl/toggle_event_counter_if.sv
`default_nettype none
// ============================================================================
//  Module   : toggle_event_counter_if
//  Brief    : Control/status bundle of the windowed toggle event counter.
//  Revision : 1.0 - initial release
// ============================================================================
interface toggle_event_counter_if #(
    parameter int CNT_W = 8,
    parameter int WIN_W = 16
);
    logic             start;
    logic [WIN_W-1:0] win_len;
    logic [CNT_W-1:0] count;
    logic             busy;
    logic             done;
    logic             ovf;

    modport master (
        output start, win_len,
        input  count, busy, done, ovf
    );

    modport slave (
        input  start, win_len,
        output count, busy, done, ovf
    );
endinterface
`default_nettype wire

// File: rtl/toggle_event_counter.sv
`default_nettype none
// ============================================================================
//  Module   : toggle_event_counter
//  Brief    : Counts level changes of an asynchronous toggle signal over a
//             programmable window of clk cycles, with saturation flag.
//  Revision : 1.0 - initial release
// ============================================================================
module toggle_event_counter #(
    parameter int CNT_W = 8,
    parameter int WIN_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     tog,
    toggle_event_counter_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
    localparam logic [WIN_W-1:0] c_TIMER_LAST = WIN_W'(1);

    state_t           r_state;
    logic             r_s1;
    logic             r_s2;
    logic             r_s3;
    logic [CNT_W-1:0] r_count;
    logic             r_ovf;
    logic [WIN_W-1:0] r_timer;

    logic             w_event;
    logic             w_cnt_max;

    // Edge detector runs in every state so a window never opens on a stale edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= tog;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign w_event   = r_s2 ^ r_s3;
    assign w_cnt_max = (r_count == c_CNT_MAX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_timer <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_count <= '0;
                        r_ovf   <= 1'b0;
                        r_timer <= bus.win_len;
                        r_state <= (bus.win_len == '0) ? ST_DONE : ST_COUNT;
                    end
                end
                ST_COUNT: begin
                    r_timer <= r_timer - c_TIMER_LAST;
                    if (w_event) begin
                        if (w_cnt_max) begin
                            r_ovf <= 1'b1;
                        end else begin
                            r_count <= r_count + CNT_W'(1);
                        end
                    end
                    if (r_timer == c_TIMER_LAST) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.count = r_count;
    assign bus.ovf   = r_ovf;
    assign bus.busy  = (r_state == ST_COUNT);
    assign bus.done  = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: doc/toggle_event_counter.md
TOGGLE_EVENT_COUNTER -- requirements
Module: toggle_event_counter

Interface
REQ-001 Parameter CNT_W, default 8: width of the event count.
REQ-002 Parameter WIN_W, default 16: width of the window-length input and internal window timer.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 tog  input  1  toggle-flop output; every level change is one event; asynchronous to clk.
REQ-006 start  input  1  request to begin a measurement window; honoured only in IDLE.
REQ-007 win_len  input  WIN_W  window length in clk cycles; sampled only when start is accepted.
REQ-008 count  output  CNT_W  number of tog events seen in the last or current window.
REQ-009 busy  output  1  high while in COUNT state.
REQ-010 done  output  1  one-cycle pulse in DONE state.
REQ-011 ovf  output  1  sticky saturation flag for the current or last window.

Function
REQ-012 tog SHALL pass through a 2-flop synchroniser (s1, s2) followed by a delay flop (s3); event = s2 XOR s3.
REQ-013 Synchroniser and edge-detect flops SHALL run in every state, so no stale transition is counted at window start.
REQ-014 A tog transition meeting setup before edge k SHALL raise event during the cycle after edge k+1 and be counted at edge k+2.
REQ-015 FSM states: IDLE, COUNT, DONE; encoding free.
REQ-016 IDLE + start=1 + win_len!=0 -> COUNT at the next edge; same edge: count<=0, ovf<=0, timer<=win_len.
REQ-017 IDLE + start=1 + win_len==0 -> DONE at the next edge; same edge: count<=0, ovf<=0.
REQ-018 IDLE + start=0: hold state; count and ovf hold their values; events are ignored.
REQ-019 COUNT, every cycle: timer decrements by 1; if event=1, count increments.
REQ-020 COUNT with timer==1 -> DONE at the next edge; an event in that last cycle SHALL be counted.
REQ-021 Window length: exactly win_len cycles in COUNT.
REQ-022 DONE lasts one cycle, then -> IDLE unconditionally.
REQ-023 start SHALL be ignored in COUNT and DONE; there is no queuing.
REQ-024 count SHALL saturate at 2^CNT_W-1.
REQ-025 An event arriving while count is at 2^CNT_W-1 SHALL set ovf; ovf clears only on the next accepted start.
REQ-026 busy=1 iff state==COUNT; done=1 iff state==DONE; both are decoded directly from registered state.
REQ-027 count and ovf SHALL be registered outputs and hold after DONE until the next accepted start.
REQ-028 win_len changes outside start acceptance SHALL have no effect on the running window.

Reset
REQ-029 On reset=0, asynchronously: state=IDLE, count=0, ovf=0, busy=0, done=0, timer=0, s1=s2=s3=0.
REQ-030 Reset asserted mid-COUNT or in DONE SHALL abort immediately; no done pulse on release.
REQ-031 After release with tog=1, the spurious 0->1 event SHALL occur in IDLE and not be counted.
REQ-032 The first start is accepted at the first rising edge after reset deasserts.

Verification
REQ-033 Basic count: win_len=20; 5 tog transitions spaced 3 cycles, all inside the window -> busy high 20 cycles; then done pulse 1 cycle; count=5, ovf=0.
REQ-034 Last-cycle and latency: tog transition timed so its event occurs in the final COUNT cycle -> counted, count=1. Transition 1 cycle later -> count=0.
REQ-035 Saturation: CNT_W=3, win_len=40, tog toggled every 2 cycles (~18 events) -> count=7, ovf=1. Next start clears both to 0.
REQ-036 Zero window: win_len=0 with start -> done pulses 1 cycle after start; busy never rises; count=0.
REQ-037 Ignored start and win_len change: start pulsed mid-COUNT and win_len changed to 3 -> window still ends at the original length; exactly one done pulse.
REQ-038 Reset mid-window and after release: reset=0 at cycle 10 of a 50-cycle window -> outputs 0 at once, state IDLE, no done pulse. Release with tog=1 held, then start with win_len=10 and no further toggles -> count=0.
